pick_controller: RTL and testbench

- Upstream stage of each lock level: converts the USB keyboard keycode and the VGA frame pulse into pick position (pickY, pickLRx) and tension strobe (openner).
- The active level block consumes these outputs to select a pin lane and to judge an open attempt.
- Also counts tension attempts per level, which drive the guesses display.

---
 rtl/pick_controller_if.sv | 20 ++
 rtl/pick_controller.sv | 146 ++++++++++++++
 tb/tb_pick_controller.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pick_controller_if.sv
// rtl/pick_controller_if.sv - pick controller key/level inputs and pick position outputs
interface pick_controller_if;
  logic       enable;
  logic [7:0] keycode;
  logic [9:0] pickY;
  logic [9:0] pickLRx;
  logic       openner;
  logic [2:0] attempts;
  logic       busy;

  modport master (
    output enable, keycode,
    input  pickY, pickLRx, openner, attempts, busy
  );

  modport slave (
    input  enable, keycode,
    output pickY, pickLRx, openner, attempts, busy
  );
endinterface

// File: rtl/pick_controller.sv
// rtl/pick_controller.sv - keycode and frame tick to pick position, tension strobe and attempt count
module pick_controller #(
  parameter int Y_MIN       = 32,
  parameter int Y_MAX       = 479,
  parameter int Y_HOME      = 32,
  parameter int X_MIN       = 440,
  parameter int X_HOME      = 560,
  parameter int STEP        = 4,
  parameter int HOLD_FRAMES = 30,
  parameter int COOL_FRAMES = 15
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  pick_controller_if.slave pif
);

  localparam int MAXF = (HOLD_FRAMES > COOL_FRAMES) ? HOLD_FRAMES : COOL_FRAMES;
  localparam int CW   = (MAXF > 2) ? $clog2(MAXF) : 1;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  typedef enum logic [1:0] {IDLE, MOVE, TENSION, COOLDOWN} state_t;

  state_t        state;
  logic [1:0]    frame_sync;
  logic          frame_prev;
  logic          tick;
  logic          enable_d;
  logic [CW-1:0] frame_cnt;
  logic [9:0]    pick_y;
  logic [9:0]    pick_x;
  logic          openner_q;
  logic [2:0]    attempts_q;
  logic          busy_q;

  // Clamped next positions, computed one bit wider so neither direction can wrap.
  logic [10:0] y_up, y_dn, x_up, x_dn;

  always_comb begin
    y_up = {1'b0, pick_y} + 11'(STEP);
    x_up = {1'b0, pick_x} + 11'(STEP);
    if (y_up > 11'(Y_MAX)) y_up = 11'(Y_MAX);
    if (x_up > 11'(X_HOME)) x_up = 11'(X_HOME);
    if ({1'b0, pick_y} < 11'(Y_MIN + STEP)) y_dn = 11'(Y_MIN);
    else                                    y_dn = {1'b0, pick_y} - 11'(STEP);
    if ({1'b0, pick_x} < 11'(X_MIN + STEP)) x_dn = 11'(X_MIN);
    else                                    x_dn = {1'b0, pick_x} - 11'(STEP);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      frame_sync <= 2'b00;
      frame_prev <= 1'b0;
      tick       <= 1'b0;
      enable_d   <= 1'b0;
      frame_cnt  <= '0;
      pick_y     <= 10'(Y_HOME);
      pick_x     <= 10'(X_HOME);
      openner_q  <= 1'b1;
      attempts_q <= 3'd0;
      busy_q     <= 1'b0;
    end else begin
      frame_sync <= {frame_sync[0], frame_clk};
      frame_prev <= frame_sync[1];
      tick       <= frame_sync[1] & ~frame_prev;
      enable_d   <= pif.enable;

      // Level abort overrides any tick landing in the same cycle.
      if (state != IDLE && !pif.enable) begin
        state     <= IDLE;
        pick_y    <= 10'(Y_HOME);
        pick_x    <= 10'(X_HOME);
        openner_q <= 1'b1;
        busy_q    <= 1'b0;
        frame_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            pick_y    <= 10'(Y_HOME);
            pick_x    <= 10'(X_HOME);
            openner_q <= 1'b1;
            busy_q    <= 1'b0;
            if (pif.enable && !enable_d) begin
              state      <= MOVE;
              attempts_q <= 3'd0;
            end
          end
          MOVE: begin
            if (tick) begin
              case (pif.keycode)
                KEY_W: pick_y <= y_dn[9:0];
                KEY_S: pick_y <= y_up[9:0];
                KEY_A: pick_x <= x_dn[9:0];
                KEY_D: pick_x <= x_up[9:0];
                KEY_SPACE: begin
                  state     <= TENSION;
                  openner_q <= 1'b0;
                  busy_q    <= 1'b1;
                  frame_cnt <= '0;
                  if (attempts_q != 3'd7) attempts_q <= attempts_q + 3'd1;
                end
                default: ;
              endcase
            end
          end
          TENSION: begin
            if (tick) begin
              if (frame_cnt == CW'(HOLD_FRAMES - 1)) begin
                state     <= COOLDOWN;
                openner_q <= 1'b1;
                frame_cnt <= '0;
              end else begin
                frame_cnt <= frame_cnt + 1'b1;
              end
            end
          end
          COOLDOWN: begin
            if (tick) begin
              if (frame_cnt == CW'(COOL_FRAMES - 1)) begin
                state     <= MOVE;
                busy_q    <= 1'b0;
                frame_cnt <= '0;
              end else begin
                frame_cnt <= frame_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign pif.pickY    = pick_y;
  assign pif.pickLRx  = pick_x;
  assign pif.openner  = openner_q;
  assign pif.attempts = attempts_q;
  assign pif.busy     = busy_q;

endmodule

// File: tb/tb_pick_controller.sv
// tb/tb_pick_controller.sv - randomized keycode/frame stimulus against a tick-level pick model
module tb_pick_controller;

  logic Clk = 1'b0;
  logic Reset_n;
  logic frame_clk;

  pick_controller_if pif ();

  pick_controller dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .pif       (pif)
  );

  always #10 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference: mode plus "ticks remaining" in the current timed phase.
  typedef enum int {M_IDLE, M_MOVE, M_TEN, M_COOL} mode_t;
  mode_t m_mode;
  int m_y, m_x, m_open, m_att, m_busy, m_left, m_en;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pickY"},    int'(pif.pickY),    m_y);
    chk({tag, ".pickLRx"},  int'(pif.pickLRx),  m_x);
    chk({tag, ".openner"},  int'(pif.openner),  m_open);
    chk({tag, ".attempts"}, int'(pif.attempts), m_att);
    chk({tag, ".busy"},     int'(pif.busy),     m_busy);
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_y = 32; m_x = 560; m_open = 1; m_att = 0; m_busy = 0; m_left = 0; m_en = 0;
  endtask

  task automatic model_tick(input logic [7:0] key);
    case (m_mode)
      M_MOVE: begin
        if (key == 8'h1A) m_y = (m_y - 4 < 32) ? 32 : m_y - 4;
        else if (key == 8'h16) m_y = (m_y + 4 > 479) ? 479 : m_y + 4;
        else if (key == 8'h04) m_x = (m_x - 4 < 440) ? 440 : m_x - 4;
        else if (key == 8'h07) m_x = (m_x + 4 > 560) ? 560 : m_x + 4;
        else if (key == 8'h2C) begin
          m_mode = M_TEN; m_left = 30; m_open = 0; m_busy = 1;
          m_att = (m_att == 7) ? 7 : m_att + 1;
        end
      end
      M_TEN: begin
        m_left--;
        if (m_left == 0) begin m_mode = M_COOL; m_left = 15; m_open = 1; end
      end
      M_COOL: begin
        m_left--;
        if (m_left == 0) begin m_mode = M_MOVE; m_busy = 0; end
      end
      default: ;
    endcase
  endtask

  // One frame_clk pulse with a given key held; outputs must not move before the tick lands.
  task automatic frame_tick(input logic [7:0] key, input string tag);
    pif.keycode = key;
    frame_clk = 1'b1;
    @(posedge Clk); @(negedge Clk);
    chk({tag, ".pre_tick_pickY"}, int'(pif.pickY), m_y);
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    model_tick(key);
    check_all(tag);
  endtask

  task automatic set_enable(input logic v);
    pif.enable = v;
    @(posedge Clk); @(negedge Clk);
    if (!v && m_mode != M_IDLE) begin
      m_mode = M_IDLE; m_y = 32; m_x = 560; m_open = 1; m_busy = 0;
    end else if (v && m_en == 0 && m_mode == M_IDLE) begin
      m_mode = M_MOVE; m_att = 0;
    end
    m_en = v;
    check_all(v ? "enable_rise" : "enable_fall");
  endtask

  function automatic logic [7:0] rand_key();
    int r;
    r = $urandom_range(0, 99);
    if (r < 22) return 8'h1A;
    if (r < 44) return 8'h16;
    if (r < 64) return 8'h04;
    if (r < 84) return 8'h07;
    if (r < 87) return 8'h2C;
    if (r < 94) return 8'h00;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    Reset_n = 1'b0;
    frame_clk = 1'b0;
    pif.enable = 1'b0;
    pif.keycode = 8'h00;
    model_reset();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check_all("reset");

    frame_tick(8'h16, "idle_frame");
    set_enable(1'b1);

    repeat (10)  frame_tick(8'h16, "down10");
    repeat (110) frame_tick(8'h16, "down_clamp");
    repeat (32)  frame_tick(8'h04, "left_clamp");
    repeat (32)  frame_tick(8'h07, "right_clamp");
    repeat (115) frame_tick(8'h1A, "up_clamp");

    for (int a = 0; a < 9; a++) begin
      frame_tick(8'h2C, "tension_start");
      repeat (45) frame_tick(8'h1A, "tension_w");
    end

    set_enable(1'b0);
    set_enable(1'b1);

    repeat (42) frame_tick(8'h16, "to200");
    chk("at200", int'(pif.pickY), 200);
    set_enable(1'b0);
    frame_tick(8'h16, "idle_frame2");
    set_enable(1'b1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        set_enable(1'b0);
        if ($urandom_range(0, 1) == 1) frame_tick(rand_key(), "rand_idle");
        set_enable(1'b1);
      end else begin
        frame_tick(rand_key(), "rand");
      end
    end

    for (int i = 0; i < 50 && m_mode != M_MOVE; i++) frame_tick(8'h00, "drain");
    frame_tick(8'h2C, "pre_reset_tension");
    repeat (5) frame_tick(8'h00, "pre_reset_hold");
    #5 Reset_n = 1'b0;
    #1 model_reset();
    check_all("async_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
